sat_scale_ctrl: RTL
===================

# sat_scale_ctrl

Sequences 16-lane FFT butterfly outputs through a shared shift-and-saturate stage, one block per accepted beat, with a valid/ready handshake on both sides. It tracks block position within an FFT frame, counts saturated lanes per frame, and picks the right-shift applied to the next frame (automatic block-floating-point scaling or a fixed software value). It sits between a butterfly stage output (WIDTH-bit) and the next stage's SAT_WIDTH-bit input.

## Interface
- WIDTH, 13, signed input sample width
- SAT_WIDTH, 12, signed output sample width
- LANES, 16, samples per beat
- BLK_PER_FRAME, 32, beats per frame (512-point FFT)
- MAX_SHIFT, 3, largest right shift applied
- SAT_THR, 4, frame saturated-lane count above which auto mode increments shift
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- din  in  LANES x WIDTH signed  input samples
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- dout  out  LANES x SAT_WIDTH signed  shifted, saturated samples
- out_last  out  1  marks last beat of frame
- auto_scale  in  1  1: adaptive shift; 0: shift from shift_cfg
- shift_cfg  in  2  fixed shift, sampled only at frame start
- cur_shift  out  2  shift applied to current frame
- frame_done  out  1  one-cycle pulse after a frame's last beat is accepted
- frame_sat_cnt  out  16  saturated-lane count of last completed frame, held until next frame_done

## Operation
- FSM states: IDLE (blk_cnt=0, no frame open), FRAME (mid-frame), UPDATE (one cycle, scaling decision).
- IDLE: in_ready = output stage free. On accept: if auto_scale=0, cur_shift <= min(shift_cfg, MAX_SHIFT) and this beat already uses the new value; otherwise cur_shift is unchanged. blk_cnt <= 1. Go to FRAME, or UPDATE if BLK_PER_FRAME=1.
- FRAME: each accept increments blk_cnt. The beat with blk_cnt = BLK_PER_FRAME-1 carries out_last=1 and moves the FSM to UPDATE.
- UPDATE: in_ready=0. frame_done=1. frame_sat_cnt <= the accumulator. If auto_scale=1:
  - accumulator > SAT_THR: cur_shift <= min(cur_shift+1, MAX_SHIFT).
  - accumulator = 0 and headroom flag set: cur_shift <= max(cur_shift-1, 0).
  - otherwise hold.
- After UPDATE: clear the accumulator, headroom flag and blk_cnt, then go to IDLE.
- Per lane datapath: s = din >>> cur_shift (arithmetic shift, truncating). dout = 2^(SAT_WIDTH-1)-1 if s ≥ that value, -2^(SAT_WIDTH-1) if s ≤ that value, else s.
- A lane is counted as saturated only if s > 2^(SAT_WIDTH-1)-1 or s < -2^(SAT_WIDTH-1). Values exactly at a limit do not count.
- Per beat, add the popcount (0..LANES) to the 16-bit accumulator. The accumulator saturates at 65535 and does not wrap.
- Headroom flag: starts at 1 each frame. Cleared if any lane's s satisfies |s| ≥ 2^(SAT_WIDTH-2) (for negative s: s < -2^(SAT_WIDTH-2)).

## Timing
- Output register stage: accepted beat appears on dout/out_valid/out_last the next cycle. Latency is 1.
- in_ready = (state≠UPDATE) && (!out_valid || out_ready). Full throughput: 1 beat/cycle.
- out_valid stays high with dout stable until out_ready.
- A frame occupies BLK_PER_FRAME accepting cycles plus 1 UPDATE cycle. The first beat of the next frame can be accepted the cycle after UPDATE.
- frame_done asserts in UPDATE, which is the cycle after last-beat acceptance. It coincides with out_valid/out_last of that beat.
- A new cur_shift is visible from the cycle after UPDATE.
- Output backpressure during UPDATE does not delay UPDATE. The pending out_last beat simply holds.
- Reset: state=IDLE, blk_cnt=0, cur_shift=0, accumulator=0, headroom=1, out_valid=0, out_last=0, dout=0, frame_done=0, frame_sat_cnt=0. in_ready=0 while rst=1.
- Reset mid-frame discards the partial frame and any held output beat. No frame_done is produced.
- auto_scale and shift_cfg changes mid-frame have no effect until the next IDLE accept or UPDATE.

## Test plan
- Passthrough: auto_scale=0, shift_cfg=0, din lanes ±100, -2048, 2047 → dout identical, out_last on beat 32, frame_done the next cycle with frame_sat_cnt=0.
- Clip and count: shift 0, one beat with all 16 lanes =4095 and one beat with 2 lanes =-4096 → those lanes clip to 2047 / -2048, frame_sat_cnt=18. Lanes exactly at 2047 count 0.
- Auto up/down: auto_scale=1, frame with 5 saturated lanes → cur_shift 0→1. Then a frame of all lanes ±200 → cur_shift 1→0. Five consecutive overloaded frames → cur_shift stops at 3.
- Backpressure: out_ready toggled randomly at 50% → no beat lost or duplicated, dout stable while stalled, in_ready=0 during UPDATE.
- Reset at beat 10 of a frame → all outputs at reset values next cycle, no frame_done. The next frame counts from blk_cnt 0.
- Fixed shift: shift_cfg=2 at frame start, din=4000 → dout=1000. shift_cfg changed to 0 mid-frame → still 1000 until the next frame.

Source files
------------

// File: rtl/sat_scale_ctrl.sv
// Shift-and-saturate stage between FFT butterfly passes, with per-frame
// saturation counting and block-floating-point shift selection.
module sat_scale_ctrl #(
    parameter int WIDTH         = 13,
    parameter int SAT_WIDTH     = 12,
    parameter int LANES         = 16,
    parameter int BLK_PER_FRAME = 32,
    parameter int MAX_SHIFT     = 3,
    parameter int SAT_THR       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       din,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*SAT_WIDTH-1:0]   dout,
    output logic                         out_last,
    input  logic                         auto_scale,
    input  logic [1:0]                   shift_cfg,
    output logic [1:0]                   cur_shift,
    output logic                         frame_done,
    output logic [15:0]                  frame_sat_cnt
);

    localparam int CNT_W = $clog2(BLK_PER_FRAME + 1);
    localparam int LCW   = $clog2(LANES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FRAME  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam int SAT_MAX_I  = 2 ** (SAT_WIDTH - 1) - 1;
    localparam int SAT_MIN_I  = -(2 ** (SAT_WIDTH - 1));
    localparam int HEAD_POS_I = 2 ** (SAT_WIDTH - 2);
    localparam int HEAD_NEG_I = -(2 ** (SAT_WIDTH - 2));

    localparam logic signed [WIDTH-1:0] SAT_MAX  = WIDTH'(SAT_MAX_I);
    localparam logic signed [WIDTH-1:0] SAT_MIN  = WIDTH'(SAT_MIN_I);
    localparam logic signed [WIDTH-1:0] HEAD_POS = WIDTH'(HEAD_POS_I);
    localparam logic signed [WIDTH-1:0] HEAD_NEG = WIDTH'(HEAD_NEG_I);
    localparam logic [1:0]              MAX_SH   = 2'(MAX_SHIFT);

    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           blk_cnt_q, blk_cnt_d;
    logic [1:0]                 cur_shift_q, cur_shift_d;
    logic [15:0]                acc_q, acc_d;
    logic                       headroom_q, headroom_d;
    logic [15:0]                frame_sat_cnt_q, frame_sat_cnt_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [LANES*SAT_WIDTH-1:0] dout_q, dout_d;

    logic                       accept;
    logic                       is_last;
    logic [1:0]                 cfg_shift;
    logic [1:0]                 beat_shift;
    logic signed [WIDTH-1:0]    lane_s [LANES];
    logic [LANES*SAT_WIDTH-1:0] lane_dout;
    logic [LCW-1:0]             sat_lanes;
    logic                       headroom_hit;
    logic [16:0]                acc_sum;
    logic [15:0]                acc_add;

    always_comb begin
        in_ready  = !rst && (state_q != S_UPDATE) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        is_last   = (blk_cnt_q == CNT_W'(BLK_PER_FRAME - 1));
        cfg_shift = (shift_cfg > MAX_SH) ? MAX_SH : shift_cfg;
        // The first beat of a fixed-shift frame already uses the newly sampled value.
        beat_shift = (state_q == S_IDLE && !auto_scale) ? cfg_shift : cur_shift_q;
    end

    always_comb begin
        lane_dout    = '0;
        sat_lanes    = '0;
        headroom_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_s[i] = $signed(din[i*WIDTH +: WIDTH]) >>> beat_shift;
            if (lane_s[i] >= SAT_MAX) begin
                lane_dout[i*SAT_WIDTH +: SAT_WIDTH] = SAT_MAX[SAT_WIDTH-1:0];
            end else if (lane_s[i] <= SAT_MIN) begin
                lane_dout[i*SAT_WIDTH +: SAT_WIDTH] = SAT_MIN[SAT_WIDTH-1:0];
            end else begin
                lane_dout[i*SAT_WIDTH +: SAT_WIDTH] = lane_s[i][SAT_WIDTH-1:0];
            end
            // Lanes sitting exactly on a rail lost nothing, so they are not counted.
            if (lane_s[i] > SAT_MAX || lane_s[i] < SAT_MIN) begin
                sat_lanes = sat_lanes + LCW'(1);
            end
            if (lane_s[i] >= HEAD_POS || lane_s[i] < HEAD_NEG) begin
                headroom_hit = 1'b1;
            end
        end
        acc_sum = {1'b0, acc_q} + 17'(sat_lanes);
        acc_add = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    end

    always_comb begin
        state_d         = state_q;
        blk_cnt_d       = blk_cnt_q;
        cur_shift_d     = cur_shift_q;
        acc_d           = acc_q;
        headroom_d      = headroom_q;
        frame_sat_cnt_d = frame_sat_cnt_q;
        out_valid_d     = out_valid_q;
        out_last_d      = out_last_q;
        dout_d          = dout_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = is_last;
            dout_d      = lane_dout;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE, S_FRAME: begin
                if (accept) begin
                    if (state_q == S_IDLE && !auto_scale) begin
                        cur_shift_d = cfg_shift;
                    end
                    blk_cnt_d  = blk_cnt_q + CNT_W'(1);
                    acc_d      = acc_add;
                    headroom_d = headroom_q && !headroom_hit;
                    state_d    = is_last ? S_UPDATE : S_FRAME;
                end
            end
            S_UPDATE: begin
                frame_sat_cnt_d = acc_q;
                if (auto_scale) begin
                    if (acc_q > 16'(SAT_THR)) begin
                        cur_shift_d = (cur_shift_q >= MAX_SH) ? MAX_SH : cur_shift_q + 2'd1;
                    end else if (acc_q == 16'd0 && headroom_q) begin
                        cur_shift_d = (cur_shift_q == 2'd0) ? 2'd0 : cur_shift_q - 2'd1;
                    end
                end
                acc_d      = '0;
                headroom_d = 1'b1;
                blk_cnt_d  = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            blk_cnt_q       <= '0;
            cur_shift_q     <= '0;
            acc_q           <= '0;
            headroom_q      <= 1'b1;
            frame_sat_cnt_q <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            dout_q          <= '0;
        end else begin
            state_q         <= state_d;
            blk_cnt_q       <= blk_cnt_d;
            cur_shift_q     <= cur_shift_d;
            acc_q           <= acc_d;
            headroom_q      <= headroom_d;
            frame_sat_cnt_q <= frame_sat_cnt_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            dout_q          <= dout_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign dout          = dout_q;
    assign cur_shift     = cur_shift_q;
    assign frame_done    = (state_q == S_UPDATE);
    assign frame_sat_cnt = frame_sat_cnt_q;

endmodule
